// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared definitions for the sequence-detector controller:
//                controller state enum, detector one-hot state encodings and
//                a reference next-state function for the detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Controller phases
    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_FLUSH = 2'd1,
        CS_SHIFT = 2'd2,
        CS_DRAIN = 2'd3
    } ctrl_state_e;

    // Detector one-hot state encodings
    localparam logic [2:0] DET_IDLE    = 3'b001;
    localparam logic [2:0] DET_STATE_1 = 3'b010;
    localparam logic [2:0] DET_FINAL   = 3'b100;

    // Two-consecutive-ones detector: a 0 always returns to IDLE, a 1 advances
    // IDLE->STATE_1 and anything else to FINAL.
    function automatic logic [2:0] det_next(input logic [2:0] cur, input logic a);
        logic [2:0] nxt;
        if (!a) begin
            nxt = DET_IDLE;
        end else if (cur == DET_IDLE) begin
            nxt = DET_STATE_1;
        end else begin
            nxt = DET_FINAL;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_ctrl_if
//  Description : Host-side interface of the sequence-detector controller:
//                start/pattern request and run results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_det_ctrl_if #(
    parameter int LEN   = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = $clog2(LEN)
);
    logic             start;
    logic [LEN-1:0]   pattern;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_count;
    logic             hit_found;
    logic [IDX_W-1:0] first_hit_idx;
    logic             mismatch_err;

    // Host side drives requests and observes results
    modport master (
        output start, pattern,
        input  busy, done, hit_count, hit_found, first_hit_idx, mismatch_err
    );

    // Controller side
    modport slave (
        input  start, pattern,
        output busy, done, hit_count, hit_found, first_hit_idx, mismatch_err
    );
endinterface
`default_nettype wire

// File: rtl/seq_det_shadow.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_shadow
//  Description : Shadow copy of the detector state, advanced from the same
//                registered det_a the detector sees, compared against the
//                detector flags in every sample cycle. Sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_shadow
    import seq_det_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic det_a,
    input  wire logic det_out1,
    input  wire logic det_out2,
    input  wire logic sample_en,
    input  wire logic clear,
    output logic      mismatch_err
);

    logic [2:0] r_shadow;
    logic       r_err;
    logic       w_diff;

    // Flags disagree with the shadow, or the detector claims two states at once
    always_comb begin
        w_diff = ({det_out1, det_out2} != {r_shadow == DET_STATE_1, r_shadow == DET_FINAL})
                 || (det_out1 && det_out2);
    end

    // Shadow detector follows det_a exactly as the real detector does
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= DET_IDLE;
        end else begin
            r_shadow <= det_next(r_shadow, det_a);
        end
    end

    // Sticky error, cleared only by a newly accepted run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (clear) begin
            r_err <= 1'b0;
        end else if (sample_en && w_diff) begin
            r_err <= 1'b1;
        end
    end

    assign mismatch_err = r_err;

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_ctrl
//  Description : Sequencing controller for the two-consecutive-ones detector.
//                Captures a LEN-bit pattern, flushes the detector, shifts the
//                pattern out LSB-first on det_a, counts FINAL samples and
//                pulses done. Optional detector cross-check enabled by
//                defining SEQ_DET_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int LEN   = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = $clog2(LEN)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    seq_det_ctrl_if.slave       host,
    output logic                det_a,
    input  wire logic           det_out1,
    input  wire logic           det_out2
);

    localparam logic [1:0] ST_IDLE  = CS_IDLE;
    localparam logic [1:0] ST_FLUSH = CS_FLUSH;
    localparam logic [1:0] ST_SHIFT = CS_SHIFT;
    localparam logic [1:0] ST_DRAIN = CS_DRAIN;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [LEN-1:0]   r_shreg;
    logic [IDX_W-1:0] r_bit_cnt;
    logic             r_det_a;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_hit_found;
    logic [IDX_W-1:0] r_first_idx;

    logic             w_accept;
    logic             w_sample_en;
    logic [IDX_W-1:0] w_samp_idx;
    logic             w_mismatch;

    // Detector output lags det_a by one cycle, so the sample window starts at
    // the second SHIFT cycle and ends in DRAIN; the sampled bit index is one
    // behind the bit counter.
    always_comb begin
        w_accept    = (r_state == ST_IDLE) && host.start;
        w_sample_en = 1'b0;
        w_samp_idx  = '0;
        if (r_state == ST_SHIFT && r_bit_cnt != '0) begin
            w_sample_en = 1'b1;
            w_samp_idx  = r_bit_cnt - IDX_W'(1);
        end else if (r_state == ST_DRAIN) begin
            w_sample_en = 1'b1;
            w_samp_idx  = C_LAST_IDX;
        end
    end

    // Sequencing FSM: state, shift register, bit counter, det_a, busy, done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_det_a   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_det_a <= 1'b0;
                    if (w_accept) begin
                        r_shreg <= host.pattern;
                        r_busy  <= 1'b1;
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // det_a was 0 this cycle, so the detector lands in IDLE
                    r_det_a   <= r_shreg[0];
                    r_shreg   <= r_shreg >> 1;
                    r_bit_cnt <= '0;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_bit_cnt == C_LAST_IDX) begin
                        r_det_a <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_det_a   <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_cnt <= r_bit_cnt + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_det_a <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_det_a <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Hit accounting: saturating count and index of the first hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count <= '0;
            r_hit_found <= 1'b0;
            r_first_idx <= '0;
        end else if (w_accept) begin
            r_hit_count <= '0;
            r_hit_found <= 1'b0;
            r_first_idx <= '0;
        end else if (w_sample_en && det_out2) begin
            if (r_hit_count != C_CNT_MAX) begin
                r_hit_count <= r_hit_count + CNT_W'(1);
            end
            if (!r_hit_found) begin
                r_hit_found <= 1'b1;
                r_first_idx <= w_samp_idx;
            end
        end
    end

`ifdef SEQ_DET_CHECK_EN
    seq_det_shadow u_shadow (
        .clk          (clk),
        .rst_n        (rst_n),
        .det_a        (r_det_a),
        .det_out1     (det_out1),
        .det_out2     (det_out2),
        .sample_en    (w_sample_en),
        .clear        (w_accept),
        .mismatch_err (w_mismatch)
    );
`else
    // Without the checker the STATE_1 flag has no consumer
    logic w_unused_out1;
    assign w_unused_out1 = det_out1;
    assign w_mismatch    = 1'b0;
`endif

    assign det_a              = r_det_a;
    assign host.busy          = r_busy;
    assign host.done          = r_done;
    assign host.hit_count     = r_hit_count;
    assign host.hit_found     = r_hit_found;
    assign host.first_hit_idx = r_first_idx;
    assign host.mismatch_err  = w_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_det_ctrl
//  Description : Self-checking bench for seq_det_ctrl with a behavioural
//                two-consecutive-ones detector attached (no reset on it).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

    localparam int LEN   = 16;
    localparam int CNT_W = 5;
    localparam int IDX_W = 4;

`ifdef SEQ_DET_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       det_a;
    logic       det_out1;
    logic       det_out2;
    logic [2:0] det_state;
    logic       det_hold;
    logic       force_out2;

    int checks = 0;
    int errors = 0;

    seq_det_ctrl_if #(.LEN(LEN), .CNT_W(CNT_W), .IDX_W(IDX_W)) hif ();

    seq_det_ctrl #(.LEN(LEN), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (hif),
        .det_a    (det_a),
        .det_out1 (det_out1),
        .det_out2 (det_out2)
    );

    always #5 clk = ~clk;

    // Detector: a=0 -> IDLE; a=1: IDLE->STATE_1, else -> FINAL. det_hold pins FINAL.
    always @(posedge clk) begin
        if (det_hold)
            det_state <= 3'b100;
        else if (!det_a)
            det_state <= 3'b001;
        else if (det_state == 3'b001)
            det_state <= 3'b010;
        else
            det_state <= 3'b100;
    end
    assign det_out1 = (det_state == 3'b010);
    assign det_out2 = force_out2 | (det_state == 3'b100);

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; issues start there so consecutive calls run back-to-back.
    task automatic run(input logic [15:0] p, input int exp_cnt, input logic exp_found,
                       input int exp_idx, input logic exp_mis, input int glitch_at);
        int cnt;
        hif.start   = 1'b1;
        hif.pattern = p;
        @(posedge clk);
        @(negedge clk);
        cnt       = 1;
        hif.start = 1'b0;
        det_hold  = 1'b0;
        chk("busy_cycle1", hif.busy, 1);
        while (hif.done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == glitch_at) begin
                hif.start   = 1'b1;
                hif.pattern = 16'h0000;
            end else if (cnt == glitch_at + 1) begin
                hif.start = 1'b0;
            end
        end
        chk("done_latency", cnt, 19);
        chk("busy_in_done", hif.busy, 0);
        chk("hit_count", hif.hit_count, exp_cnt);
        chk("hit_found", hif.hit_found, exp_found);
        chk("first_hit_idx", hif.first_hit_idx, exp_idx);
        chk("mismatch_err", hif.mismatch_err, exp_mis);
    endtask

    typedef struct {
        logic [15:0] pat;
        int          exp_cnt;
        logic        exp_found;
        int          exp_idx;
        int          gap;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int done_seen;

        vecs[0] = '{16'h0000,  0, 1'b0,  0, 1};
        vecs[1] = '{16'h0003,  1, 1'b1,  1, 2};
        vecs[2] = '{16'h0006,  1, 1'b1,  2, 0};
        vecs[3] = '{16'hFFFF, 15, 1'b1,  1, 0};
        vecs[4] = '{16'h5555,  0, 1'b0,  0, 3};
        vecs[5] = '{16'h8001,  0, 1'b0,  0, 0};
        vecs[6] = '{16'hC000,  1, 1'b1, 15, 1};
        vecs[7] = '{16'h00F0,  3, 1'b1,  5, 0};

        rst_n       = 1'b0;
        hif.start   = 1'b0;
        hif.pattern = '0;
        det_hold    = 1'b0;
        force_out2  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", hif.busy, 0);
        chk("rst_done", hif.done, 0);
        chk("rst_det_a", det_a, 0);
        chk("rst_hit_count", hif.hit_count, 0);
        chk("rst_hit_found", hif.hit_found, 0);
        chk("rst_first_idx", hif.first_hit_idx, 0);
        chk("rst_mismatch", hif.mismatch_err, 0);
        rst_n = 1'b1;

        // Table: gap 0 means start asserted in the previous done cycle
        for (int i = 0; i < 8; i++) begin
            repeat (vecs[i].gap) @(negedge clk);
            run(vecs[i].pat, vecs[i].exp_cnt, vecs[i].exp_found, vecs[i].exp_idx, 1'b0, 0);
        end

        // Start and pattern change during SHIFT are ignored
        @(negedge clk);
        run(16'hFFFF, 15, 1'b1, 1, 1'b0, 5);

        // Results hold in IDLE, done is a single pulse
        repeat (3) @(negedge clk);
        chk("hold_done", hif.done, 0);
        chk("hold_hit_count", hif.hit_count, 15);
        chk("hold_hit_found", hif.hit_found, 1);

        // Reset in the 5th SHIFT cycle (cycle 6)
        hif.start   = 1'b1;
        hif.pattern = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        hif.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", hif.busy, 1);
        chk("mid_hit_count", hif.hit_count, 2);
        chk("mid_det_a", det_a, 1);
        det_hold = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("arst_busy", hif.busy, 0);
        chk("arst_hit_count", hif.hit_count, 0);
        chk("arst_hit_found", hif.hit_found, 0);
        chk("arst_det_a", det_a, 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (hif.done === 1'b1) done_seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (hif.done === 1'b1) done_seen++;
        chk("no_done_after_reset", done_seen, 0);
        chk("det_left_final", det_out2, 1);
        // FLUSH must clear the stale FINAL state
        run(16'h0000, 0, 1'b0, 0, 1'b0, 0);

        if (CHK_EN) begin
            // Stuck FINAL flag: every sample is a hit, and the checker flags it
            @(negedge clk);
            force_out2 = 1'b1;
            run(16'h0000, 16, 1'b1, 0, 1'b1, 0);
            force_out2 = 1'b0;
            @(negedge clk);
            run(16'h0003, 1, 1'b1, 1, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Sequencing controller for the two-consecutive-ones sequence detector (`fsm`). It captures a LEN-bit pattern on a start pulse and flushes the detector to IDLE. It then serializes the pattern onto the detector's `a` input LSB-first, counts the cycles in which the detector reports FINAL, and signals completion with a one-cycle done pulse. It sits between a register/host interface and the detector instance, which has no reset of its own.

## Interface
- `LEN`, 16, pattern length in bits (≥2)
- `CNT_W`, 5, width of hit counter
- `IDX_W`, $clog2(LEN), width of hit index
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  request; accepted only in IDLE
- `pattern`  in  LEN  bit pattern, captured on accepted start
- `busy`  out  1  high from cycle after accepted start until done cycle (exclusive)
- `done`  out  1  one-cycle pulse, results valid
- `det_a`  out  1  registered drive to detector input `a`
- `det_out1`  in  1  detector STATE_1 flag
- `det_out2`  in  1  detector FINAL flag
- `hit_count`  out  CNT_W  number of FINAL samples, saturating
- `hit_found`  out  1  at least one hit in last run
- `first_hit_idx`  out  IDX_W  pattern bit index of first hit
- `mismatch_err`  out  1  sticky detector-check error (see Configuration)

## Operation
- States: IDLE, FLUSH, SHIFT, DRAIN.
- IDLE: `start`=1 → capture `pattern` into shift register, clear `hit_count`, `hit_found`, `first_hit_idx`, `mismatch_err`, go FLUSH. `start` in any other state is ignored.
- FLUSH (1 cycle): `det_a`=0, which forces the detector to IDLE from any state, including X. Go SHIFT.
- SHIFT (LEN cycles): `det_a`=pattern bit i in the i-th SHIFT cycle, LSB first. Bit counter runs 0..LEN-1. After the last bit, go DRAIN.
- DRAIN (1 cycle): `det_a`=0. Take the final sample. Go IDLE and pulse `done`.
- Hit sampling: detector output for bit i is visible one cycle after bit i is driven. `det_out2` is sampled in the cycles from the 2nd SHIFT cycle through DRAIN, giving LEN samples. A sample of 1 means bit i is a hit, i.e. bits i-1 and i are both 1.
- `hit_count` increments per hit and saturates at 2^CNT_W-1.
- First hit: set `hit_found`=1 and `first_hit_idx`=i. Later hits do not change the index.
- Results hold in IDLE until the next accepted start.

## Timing
- Start sampled at edge E0 → FLUSH in cycle 1 → SHIFT in cycles 2..LEN+1 → DRAIN in cycle LEN+2 → `done`=1 in cycle LEN+3. `busy`=0 in that cycle.
- A new start is accepted in the `done` cycle, so back-to-back runs have a period of LEN+3.
- Reset values: `busy` 0, `done` 0, `det_a` 0, `hit_count` 0, `hit_found` 0, `first_hit_idx` 0, `mismatch_err` 0, state IDLE.
- Reset mid-run: everything returns to reset values immediately and no `done` is issued. Detector state is then arbitrary; the next run's FLUSH re-initializes it.
- `pattern` changes during a run have no effect.

## Configuration
- `SEQ_DET_CHECK_EN` defined: an internal shadow of the detector state is updated from `det_a`.
  - In each sample cycle from SHIFT cycle 1 through DRAIN, {`det_out1`,`det_out2`} is compared against the shadow.
  - Any difference, or both flags high, sets `mismatch_err`. It stays set until the next accepted start.
- Not defined: `mismatch_err` is tied to 0 and no shadow logic exists.

## Structure
- Shared package `seq_det_pkg`: state enum (IDLE/FLUSH/SHIFT/DRAIN) and detector one-hot encodings (3'b001/3'b010/3'b100), reused by the shadow model.
- One sub-module, `seq_det_shadow`, holds the detector shadow and compare logic. It is instantiated only under `SEQ_DET_CHECK_EN`.

## Test plan
All scenarios use LEN=16 and CNT_W=5, with a real `fsm` instance connected.
- `pattern`=16'h0000 → `done` 19 cycles after start; `hit_count`=0, `hit_found`=0.
- 16'h0003 → `hit_count`=1, `hit_found`=1, `first_hit_idx`=1. 16'h0006 → `first_hit_idx`=2.
- 16'hFFFF → `hit_count`=15, `first_hit_idx`=1. 16'h5555 → `hit_count`=0.
- Start pulsed during SHIFT → ignored, results unchanged. Back-to-back start in the `done` cycle → second run completes 19 cycles later with its own results.
- `rst_n` low in the 5th SHIFT cycle → all outputs 0 asynchronously and no `done`. Detector left in FINAL; next run with 16'h0000 still reports `hit_count`=0.
- With `SEQ_DET_CHECK_EN`, a bench forces `det_out2`=1 throughout → `mismatch_err`=1 at `done`. A normal detector gives `mismatch_err`=0.
